dmem_dump_ctrl: RTL and testbench
=================================

# dmem_dump_ctrl

Halt-and-dump sequencer that owns the data-memory port of the `mipse` system. During normal execution it passes CPU accesses straight through to `dmem`. When the CPU stores to the halt address, it freezes the CPU and takes over the `dmem` address port. It then streams a fixed window of data-memory words out on a valid/ready interface, for result checking or export. It sits between `mipse`, `dmem` and the result sink, replacing bench-side memory peeking and finish detection.

## Interface
Parameters:
- `DATA_W`, 32, data and CPU address width
- `ADDR_W`, 16, dmem word-address width (`mem_a`)
- `HALT_ADDR`, 32'h0000_7fff, CPU byte address whose store triggers halt; compared on all 32 bits
- `DUMP_START`, 256, first dmem word index dumped
- `DUMP_END`, 1023, last dmem word index dumped; must satisfy DUMP_START <= DUMP_END <= 1023

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_daddr`  in  DATA_W  CPU data byte address (`aluresult`)
- `cpu_we`  in  1  CPU store strobe (`memwrite`)
- `cpu_wd`  in  DATA_W  CPU store data
- `cpu_en`  out  1  CPU clock enable / run permission
- `mem_a`  out  ADDR_W  dmem word address
- `mem_we`  out  1  dmem write enable
- `mem_wd`  out  DATA_W  dmem write data; always equals `cpu_wd`
- `mem_rd`  in  DATA_W  dmem read data; dmem read is asynchronous
- `dump_valid`  out  1  dump beat available
- `dump_ready`  in  1  sink accepts beat
- `dump_data`  out  DATA_W  dumped word, registered
- `dump_index`  out  10  dmem word index of `dump_data`, registered
- `done`  out  1  dump complete; sticky until reset
- `cycle_count`  out  32  number of RUN cycles executed

## Operation
States are RUN, DUMP and DONE. Reset enters RUN.

RUN:
- `cpu_en`=1 and `mem_a`=`cpu_daddr[ADDR_W+1:2]`.
- `mem_we`=`cpu_we & ~halt_hit`, where `halt_hit`=`cpu_we & (cpu_daddr==HALT_ADDR)`.
- `cycle_count` increments every RUN cycle, including the halt cycle.
- When `halt_hit` is asserted, the store is suppressed (never written), the fetch index is set to DUMP_START, and the next state is DUMP.

DUMP:
- `cpu_en`=0 and `mem_we`=0 regardless of `cpu_we`.
- `mem_a`=fetch index, zero-extended.
- Load condition: `~dump_valid | dump_ready`.
- On a load while fetch index <= DUMP_END:
  - `dump_data`<=`mem_rd` and `dump_index`<=fetch index;
  - `dump_valid`<=1;
  - fetch index increments.
- On a load when fetch index > DUMP_END: `dump_valid`<=0 and the next state is DONE.
- While `dump_valid & ~dump_ready`, `dump_data` and `dump_index` hold stable.

DONE:
- `cpu_en`=0, `mem_we`=0, `done`=1, `dump_valid`=0.
- `cycle_count` is frozen.
- Exited only by `rst`.

Width rules:
- The fetch index is 11 bits, so it can reach DUMP_END+1 without wrapping.
- `cycle_count` wraps modulo 2^32.

## Timing
Reset values, effective at the first edge with `rst`=1:
- state=RUN, `cpu_en`=1, `dump_valid`=0, `dump_data`=0, `dump_index`=0, `done`=0, `cycle_count`=0.
- `rst` overrides everything, including mid-DUMP and in DONE. The next cycle is RUN with the CPU enabled. The dmem contents are untouched.

Dump latency (halt store in cycle T):
- `cpu_en`=0 from cycle T+1.
- The first beat (index DUMP_START) is valid in cycle T+2.
- With `dump_ready` held at 1, one beat is transferred per cycle.
- The last beat is valid in cycle T+2+(DUMP_END-DUMP_START).
- `done`=1 one cycle after the last handshake.

Other timing rules:
- A non-halt store in the same cycle as `cpu_en` falling cannot occur: the halt cycle is the last CPU cycle.
- `dump_ready` may toggle arbitrarily. No beat is lost or duplicated, and indices are strictly consecutive.
- `dump_valid` never deasserts without a handshake, except on `rst`.

## Test plan
- **Pass-through:** reset, CPU stores 0x0000_1234 to 0x400, then stores to 0x7fff → `mem_we`=1 at word 0x100 in the first store cycle; `mem_we`=0 in the halt cycle; first beat is `dump_index`=256, `dump_data`=0x1234.
- **Full dump:** halt on the 5th RUN cycle after reset, `dump_ready`=1 → `cycle_count`=5; 768 beats with indices 256..1023 on consecutive cycles; `done`=1 the cycle after index 1023 is accepted; `cpu_en`=0 throughout.
- **Backpressure:** hold `dump_ready`=0 for 5 cycles at index 300, then toggle it every cycle → data and index stable while stalled; every index 256..1023 appears exactly once, in order.
- **Halt decode:** store to 0x7ffc → written normally, state stays RUN. Store to 0x7fff with `cpu_we`=0 → no halt. `cpu_we`=1 asserted during DUMP → `mem_we` stays 0.
- **Reset mid-dump:** assert `rst` after 100 accepted beats → next cycle `dump_valid`=0, `cpu_en`=1, `cycle_count`=0, `done`=0; a second halt restarts the dump at index 256.
- **Reset in DONE:** assert `rst` while `done`=1 → `done` clears; RUN resumes with `cycle_count` counting from 0.

Source files
------------

// File: rtl/dmem_dump_ctrl.sv
// Halt-and-dump sequencer: passes CPU data-memory accesses through to dmem until the CPU
// stores to HALT_ADDR, then freezes the CPU and streams a window of dmem words out.
module dmem_dump_ctrl #(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 16,
    parameter logic [DATA_W-1:0]  HALT_ADDR  = 32'h0000_7fff,
    parameter int                 DUMP_START = 256,
    parameter int                 DUMP_END   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_daddr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_en,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [9:0]        dump_index,
    output logic              done,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [10:0] START_IDX = 11'(DUMP_START);
    localparam logic [10:0] END_IDX   = 11'(DUMP_END);

    state_t      state;
    logic [10:0] fetch_idx;
    logic        halt_hit;
    logic        load;

    assign mem_wd = cpu_wd;
    assign load   = ~dump_valid | dump_ready;

    // The halting store itself must never reach dmem.
    always_comb begin
        halt_hit = cpu_we && (cpu_daddr == HALT_ADDR);
        mem_we   = 1'b0;
        mem_a    = ADDR_W'(fetch_idx);
        if (state == S_RUN) begin
            mem_we = cpu_we & ~halt_hit;
            mem_a  = cpu_daddr[ADDR_W+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            cpu_en      <= 1'b1;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_index  <= '0;
            done        <= 1'b0;
            cycle_count <= '0;
            fetch_idx   <= START_IDX;
        end else begin
            case (state)
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (halt_hit) begin
                        fetch_idx <= START_IDX;
                        cpu_en    <= 1'b0;
                        state     <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    // fetch_idx runs one past DUMP_END so the final load can retire the last beat.
                    if (load) begin
                        if (fetch_idx <= END_IDX) begin
                            dump_data  <= mem_rd;
                            dump_index <= fetch_idx[9:0];
                            dump_valid <= 1'b1;
                            fetch_idx  <= fetch_idx + 11'd1;
                        end else begin
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    cpu_en     <= 1'b0;
                    dump_valid <= 1'b0;
                    done       <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Randomized scoreboard bench for dmem_dump_ctrl with a behavioural dmem and a shadow
// memory model that predicts every dumped beat.
module tb_dmem_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_daddr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wd = '0;
    logic        cpu_en;
    logic [15:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [31:0] dump_data;
    logic [9:0]  dump_index;
    logic        done;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] dmem    [0:65535];
    logic [31:0] ref_mem [0:65535];

    always #5 clk = ~clk;

    dmem_dump_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_daddr   (cpu_daddr),
        .cpu_we      (cpu_we),
        .cpu_wd      (cpu_wd),
        .cpu_en      (cpu_en),
        .mem_a       (mem_a),
        .mem_we      (mem_we),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_index  (dump_index),
        .done        (done),
        .cycle_count (cycle_count)
    );

    // Behavioural dmem: asynchronous read, synchronous write.
    always @(posedge clk) if (mem_we) dmem[mem_a] <= mem_wd;
    assign mem_rd = dmem[mem_a];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every presented beat must match the scoreboard head, stalled or not.
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) checkOutput("valid_hold", dump_valid, 1);
            if (dump_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got index %0d expected no beat", dump_index);
                end else begin
                    checkOutput("beat_index", dump_index, sb[0].idx);
                    checkOutput("beat_data", dump_data, sb[0].data);
                    if (dump_ready) void'(sb.pop_front());
                end
            end
            prev_valid = dump_valid;
            prev_ready = dump_ready;
        end
    end

    task automatic resetDut();
        rst        = 1'b1;
        cpu_we     = 1'b0;
        dump_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_cpu_en", cpu_en, 1);
        checkOutput("rst_dump_valid", dump_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cycle_count", cycle_count, 0);
        checkOutput("rst_dump_index", dump_index, 0);
        checkOutput("rst_dump_data", dump_data, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One RUN cycle: predicted pass-through behaviour, shadow-memory update, halt scoreboarding.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        logic        hit;
        logic [15:0] widx;
        hit       = we && (addr == 32'h0000_7fff);
        widx      = addr[17:2];
        cpu_we    = we;
        cpu_daddr = addr;
        cpu_wd    = wd;
        @(negedge clk);
        checkOutput("run_cpu_en", cpu_en, 1);
        checkOutput("run_mem_we", mem_we, {31'd0, we && !hit});
        checkOutput("run_mem_a", mem_a, widx);
        if (we && !hit) ref_mem[widx] = wd;
        if (hit)
            for (int i = 256; i <= 1023; i++)
                sb.push_back(beat_t'{idx: 10'(i), data: ref_mem[i]});
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic runCpu(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 2047)) << 2, $urandom);
    endtask

    // mode 0: ready held high; 1: random ready; 2: stall 5 cycles at index 300 then toggle.
    task automatic drain(input int mode, input int beat_limit, output int done_cycle,
                         output int first_valid_cycle, output int beats);
        int stall_left;
        bit stalled;
        bit tog;
        done_cycle = 0; first_valid_cycle = 0; beats = 0;
        stall_left = 0; stalled = 0; tog = 0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            case (mode)
                0: dump_ready = 1'b1;
                1: dump_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!stalled && dump_valid && dump_index == 10'd300) begin
                        stalled    = 1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        dump_ready = 1'b0;
                        stall_left--;
                    end else if (stalled) begin
                        tog        = !tog;
                        dump_ready = tog;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
            endcase
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_daddr = ($urandom_range(0, 3) == 0) ? 32'h0000_7fff
                                                    : 32'($urandom_range(0, 2047)) << 2;
            cpu_wd    = $urandom;
            @(negedge clk);
            checkOutput("dump_cpu_en", cpu_en, 0);
            checkOutput("dump_mem_we", mem_we, 0);
            if (done) begin
                done_cycle = cyc;
                break;
            end
            if (dump_valid && first_valid_cycle == 0) first_valid_cycle = cyc;
            if (dump_valid && dump_ready) beats++;
            if (beat_limit > 0 && beats == beat_limit) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc, fv, nb;
        logic [31:0] w;
        for (int i = 0; i < 65536; i++) begin
            w          = $urandom;
            dmem[i]    = w;
            ref_mem[i] = w;
        end

        // Pass-through then a full dump with ready held high; halt on the 5th RUN cycle.
        resetDut();
        applyStimulus(1'b1, 32'h0000_0400, 32'h0000_1234);
        runCpu(3);
        applyStimulus(1'b1, 32'h0000_7fff, $urandom);
        checkOutput("halt_cycle_count", cycle_count, 5);
        checkOutput("halt_cpu_en", cpu_en, 0);
        drain(0, 0, dc, fv, nb);
        checkOutput("first_valid_cycle", fv, 2);
        checkOutput("full_beats", nb, 768);
        checkOutput("done_cycle", dc, 770);
        checkOutput("full_sb_empty", sb.size(), 0);
        checkOutput("full_done", done, 1);
        checkOutput("full_valid_low", dump_valid, 0);
        checkOutput("frozen_cycle_count", cycle_count, 5);

        // Halt decode, then a dump with backpressure at index 300.
        resetDut();
        applyStimulus(1'b1, 32'h0000_7ffc, $urandom);
        applyStimulus(1'b0, 32'h0000_7fff, $urandom);
        applyStimulus(1'b1, 32'h0000_0404, $urandom);
        runCpu(10);
        applyStimulus(1'b1, 32'h0000_7fff, $urandom);
        checkOutput("decode_cycle_count", cycle_count, 14);
        drain(2, 0, dc, fv, nb);
        checkOutput("bp_done_reached", {31'd0, dc > 0}, 1);
        checkOutput("bp_beats", nb, 768);
        checkOutput("bp_sb_empty", sb.size(), 0);

        // Reset after 100 accepted beats, then a second complete dump with random ready.
        resetDut();
        runCpu(4);
        applyStimulus(1'b1, 32'h0000_7fff, $urandom);
        drain(1, 100, dc, fv, nb);
        checkOutput("mid_beats", nb, 100);
        rst        = 1'b1;
        dump_ready = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", dump_valid, 0);
        checkOutput("mid_rst_cpu_en", cpu_en, 1);
        checkOutput("mid_rst_count", cycle_count, 0);
        checkOutput("mid_rst_done", done, 0);
        @(posedge clk); #1;
        runCpu(2);
        applyStimulus(1'b1, 32'h0000_7fff, $urandom);
        checkOutput("second_halt_count", cycle_count, 4);
        drain(1, 0, dc, fv, nb);
        checkOutput("rand_done_reached", {31'd0, dc > 0}, 1);
        checkOutput("rand_beats", nb, 768);
        checkOutput("rand_sb_empty", sb.size(), 0);

        // Reset while done is set; counting restarts from zero.
        checkOutput("pre_rst_done", done, 1);
        resetDut();
        runCpu(3);
        checkOutput("after_done_count", cycle_count, 3);
        checkOutput("after_done_cpu_en", cpu_en, 1);
        checkOutput("after_done_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
